// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: on-board exhaustive self-test for a WIDTH-bit adder.
// Walks every {a, b, ci} vector (A outer, B middle, CI inner), holds each for
// SETTLE cycles, then compares the adder's {co, sum} readback with a+b+ci.
// Optional build macro: STOP_ON_FAIL_EN -- halt on the first mismatch so the
// failing operands stay applied to the adder.
module adder_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 ci_out,
    input  logic [WIDTH-1:0]     sum_in,
    input  logic                 co_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     vec_idx,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     first_fail,
    output logic                 fail_seen
);

    localparam int IW = 2*WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = '1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_vec_idx;
    logic [IW:0]       r_err_count;
    logic [IW-1:0]     r_first_fail;
    logic              r_fail_seen;
    logic [CW-1:0]     r_settle_cnt;
    logic [WIDTH:0]    w_golden;
    logic              w_mismatch;
    logic              w_start_sweep;

    // Operands are slices of the registered vector index, so they are glitch-free.
    assign a_out      = r_vec_idx[2*WIDTH:WIDTH+1];
    assign b_out      = r_vec_idx[WIDTH:1];
    assign ci_out     = r_vec_idx[0];
    assign vec_idx    = r_vec_idx;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;
    assign fail_seen  = r_fail_seen;
    assign busy       = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done       = (r_state == S_DONE);
    assign pass       = (r_state == S_DONE) && (r_err_count == '0);

    assign w_golden      = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, ci_out};
    assign w_mismatch    = (w_golden != {co_in, sum_in});
    assign w_start_sweep = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: settle, check once, then advance or finish.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == LAST_CNT) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef STOP_ON_FAIL_EN
                if (w_mismatch || (r_vec_idx == LAST_IDX)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
`else
                if (r_vec_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sweep bookkeeping: vector index, settle timer, error tally and first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_idx    <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_settle_cnt <= '0;
        end else if (w_start_sweep) begin
            r_vec_idx    <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_settle_cnt <= '0;
        end else if (r_state == S_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end else if (r_state == S_CHECK) begin
            if (w_mismatch) begin
                r_err_count <= r_err_count + 1'b1;
                if (!r_fail_seen) begin
                    r_first_fail <= r_vec_idx;
                    r_fail_seen  <= 1'b1;
                end
            end
            // Advance only when another vector follows; in DONE the index is held.
            if (w_state_nxt == S_SETTLE) begin
                r_vec_idx    <= r_vec_idx + 1'b1;
                r_settle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Testbench for adder_sweep_checker: emulates the adder (ideal or with planted
// faults) and checks sweep timing and final status against a reference model.
module tb_adder_sweep_checker;

    localparam int W  = 4;
    localparam int NV = 512;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_out, b_out, sum_in;
    logic         ci_out, co_in;
    logic         busy, done, pass, fail_seen;
    logic [2*W:0] vec_idx, first_fail;
    logic [2*W+1:0] err_count;

    int  mode = 0;
    bit  faulty [NV];
    logic [W:0] resp;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int    mode;
        int    err;
        int    first;
        int    pass;
        int    cycles;
        int    vec;
        string name;
    } vec_t;

    vec_t tbl [3];

    adder_sweep_checker #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_out      (a_out),
        .b_out      (b_out),
        .ci_out     (ci_out),
        .sum_in     (sum_in),
        .co_in      (co_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .vec_idx    (vec_idx),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_seen  (fail_seen)
    );

    always #5 clk = ~clk;

    // Adder emulation with optional faults.
    always_comb begin
        resp = {1'b0, a_out} + {1'b0, b_out} + {{W{1'b0}}, ci_out};
        case (mode)
            1: resp[W] = 1'b0;
            2: resp[0] = ~resp[0];
            3: if (faulty[{a_out, b_out, ci_out}]) resp[1] = ~resp[1];
            default: ;
        endcase
        {co_in, sum_in} = resp;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: enumerate vectors arithmetically and apply the fault rule.
    task automatic model(input int m, output int e_err, output int e_first,
                         output int e_pass, output int e_cycles, output int e_vec);
        int cnt = 0;
        int first = -1;
        for (int i = 0; i < NV; i++) begin
            int a = i / 32;
            int b = (i / 2) % 16;
            int c = i % 2;
            int g = a + b + c;
            int r = g;
            if (m == 1) r = g % 16;
            if (m == 2) r = g ^ 1;
            if (m == 3 && faulty[i]) r = g ^ 2;
            if (r != g) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
`ifdef STOP_ON_FAIL_EN
        if (first >= 0) begin
            e_err = 1; e_first = first; e_pass = 0;
            e_cycles = (first + 1) * (ST + 1); e_vec = first;
            return;
        end
`endif
        e_err    = cnt;
        e_first  = (first < 0) ? 0 : first;
        e_pass   = (cnt == 0) ? 1 : 0;
        e_cycles = NV * (ST + 1);
        e_vec    = NV - 1;
    endtask

    // Pulse start, then count edges until done; optionally re-pulse start while busy.
    task automatic run_sweep(input bit poke, output int cycles);
        int busy_cyc = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        chk("pass_after_start", pass, 0);
        chk("vec_after_start", vec_idx, 0);
        cycles = 0;
        while (cycles < 5000) begin
            if (busy) busy_cyc++;
            @(posedge clk) #1;
            cycles++;
            start = (poke && (cycles % 97 == 5)) ? 1'b1 : 1'b0;
            if (done) break;
        end
        start = 1'b0;
        if (cycles >= 5000) chk("sweep_timeout", 0, 1);
        chk("busy_span", busy_cyc, cycles);
    endtask

    task automatic check_done(input string tag, input int e_err, input int e_first,
                              input int e_pass, input int e_vec);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass"}, pass, e_pass);
        chk({tag, "_err"}, err_count, e_err);
        chk({tag, "_first"}, first_fail, e_first);
        chk({tag, "_fseen"}, fail_seen, (e_err != 0) ? 1 : 0);
        chk({tag, "_vec"}, vec_idx, e_vec);
        chk({tag, "_a"}, a_out, e_vec / 32);
        chk({tag, "_b"}, b_out, (e_vec / 2) % 16);
        chk({tag, "_ci"}, ci_out, e_vec % 2);
    endtask

    initial begin
        int cyc, e_err, e_first, e_pass, e_cycles, e_vec, guard;

        // Asynchronous reset with no clock edge in between.
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_vec", vec_idx, 0);
        chk("rst_err", err_count, 0);
        chk("rst_a", a_out, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("idle_done", done, 0);

        tbl[0] = '{0, 0, 0, 1, 1536, 511, "ideal"};
`ifdef STOP_ON_FAIL_EN
        tbl[1] = '{1, 1, 31, 0, 96, 31, "co_stuck"};
        tbl[2] = '{2, 1, 0, 0, 3, 0, "sum0_inv"};
`else
        tbl[1] = '{1, 256, 31, 0, 1536, 511, "co_stuck"};
        tbl[2] = '{2, 512, 0, 0, 1536, 511, "sum0_inv"};
`endif

        // Table-driven directed fault modes.
        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].mode;
            run_sweep(1'b0, cyc);
            chk({tbl[i].name, "_cycles"}, cyc, tbl[i].cycles);
            check_done(tbl[i].name, tbl[i].err, tbl[i].first, tbl[i].pass, tbl[i].vec);
        end

        // Randomised sparse faults against the reference model.
        for (int r = 0; r < 3; r++) begin
            int nf = $urandom_range(1, 6);
            for (int i = 0; i < NV; i++) faulty[i] = 1'b0;
            for (int k = 0; k < nf; k++) faulty[$urandom_range(0, NV - 1)] = 1'b1;
            mode = 3;
            model(3, e_err, e_first, e_pass, e_cycles, e_vec);
            run_sweep(1'b0, cyc);
            chk("rand_cycles", cyc, e_cycles);
            check_done("rand", e_err, e_first, e_pass, e_vec);
        end

        // Start pulses while busy must not restart the sweep.
        mode = 0;
        model(0, e_err, e_first, e_pass, e_cycles, e_vec);
        run_sweep(1'b1, cyc);
        chk("poke_cycles", cyc, e_cycles);
        check_done("poke", e_err, e_first, e_pass, e_vec);

        // Reset in mid-sweep at vector 200.
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        guard = 0;
        while (vec_idx != 200 && guard < 5000) begin
            @(posedge clk) #1;
            guard++;
        end
        chk("reach_200", vec_idx, 200);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vec", vec_idx, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_a", a_out, 0);
        chk("mid_rst_b", b_out, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        chk("post_rst_idle", busy, 0);
        run_sweep(1'b0, cyc);
        chk("post_rst_cycles", cyc, 1536);
        check_done("post_rst", 0, 0, 1, 511);

        // Outputs hold in DONE.
        repeat (5) @(posedge clk);
        #1 chk("hold_done", done, 1);
        chk("hold_vec", vec_idx, 511);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
